// File: rtl/dmem_bridge_pkg.sv
// Shared types and parameter defaults for the data-memory bridge.
// Store-to-load forwarding is enabled by defining DMEM_BRIDGE_FWD_EN.
package dmem_bridge_pkg;

  localparam int AW_DEFAULT         = 32;
  localparam int DW_DEFAULT         = 32;
  localparam int WBUF_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } bridgeState_t;

  // States in which the write buffer may own the request channel.
  function automatic logic isWriteState(input bridgeState_t s);
    return (s == IDLE) || (s == DRAIN) || (s == RD_DONE);
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// In-order store buffer of {addr,data} entries; with DMEM_BRIDGE_FWD_EN it also
// exposes an oldest-to-youngest view of all entries for load forwarding.
module wbuf_fifo
  import dmem_bridge_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            pushAddr,
  input  logic [DW-1:0]            pushData,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [AW-1:0]            headAddr,
  output logic [DW-1:0]            headData
`ifdef DMEM_BRIDGE_FWD_EN
  ,
  output logic [AW-1:0]            viewAddr [DEPTH],
  output logic [DW-1:0]            viewData [DEPTH],
  output logic [DEPTH-1:0]         viewValid
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] entryAddr [DEPTH];
  logic [DW-1:0] entryData [DEPTH];
  logic [PW-1:0] rdPtrReg;
  logic [PW-1:0] wrPtrReg;
  logic [PW:0]   countReg;
  logic          doPush;
  logic          doPop;

  assign full     = (countReg == (PW+1)'(DEPTH));
  assign empty    = (countReg == '0);
  assign count    = countReg;
  assign doPop    = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign doPush   = push && (!full || doPop);
  assign headAddr = entryAddr[rdPtrReg];
  assign headData = entryData[rdPtrReg];

  always_ff @(posedge clk) begin
    if (doPush) begin
      entryAddr[wrPtrReg] <= pushAddr;
      entryData[wrPtrReg] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PW'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PW'(1);
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + (PW+1)'(1);
        2'b01:   countReg <= countReg - (PW+1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

`ifdef DMEM_BRIDGE_FWD_EN
  // Slot gi holds the gi-th oldest entry; higher slots are younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gView
    logic [PW-1:0] idx;
    assign idx           = rdPtrReg + PW'(gi);
    assign viewAddr[gi]  = entryAddr[idx];
    assign viewData[gi]  = entryData[idx];
    assign viewValid[gi] = ((PW+1)'(gi) < countReg);
  end
`endif

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: buffers stores, drains them before loads, runs a single
// outstanding read on the bus. Define DMEM_BRIDGE_FWD_EN for store-to-load forwarding.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] alu_resultM,
  input  logic [DW-1:0] write_dataM,
  input  logic          mem_writeM,
  input  logic          mem_readM,
  output logic          stall_memM,
  output logic [DW-1:0] read_dataM,
  output logic          read_validM,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_req_we,
  output logic [AW-1:0] bus_req_addr,
  output logic [DW-1:0] bus_req_wdata,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata
);

  localparam int PW = $clog2(WBUF_DEPTH);

  bridgeState_t  stateReg;
  bridgeState_t  stateNext;
  logic [AW-1:0] rdAddrReg;
  logic [DW-1:0] readDataReg;

  logic          fifoFull;
  logic          fifoEmpty;
  logic [PW:0]   fifoCount;
  logic [AW-1:0] headAddr;
  logic [DW-1:0] headData;

  logic          readReq;
  logic          startRead;
  logic          writeSel;
  logic          busPop;
  logic          storePush;
  logic          lastPop;

`ifdef DMEM_BRIDGE_FWD_EN
  logic [AW-1:0]         viewAddr [WBUF_DEPTH];
  logic [DW-1:0]         viewData [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] viewValid;
  logic [WBUF_DEPTH-1:0] fwdMatch;
  logic                  fwdHit;
  logic [DW-1:0]         fwdData;
`endif

  // A simultaneous store wins; the read is dropped for that cycle.
  assign readReq   = mem_readM && !mem_writeM;
  assign startRead = (stateReg == IDLE) && readReq;

  assign writeSel  = !fifoEmpty && isWriteState(stateReg);
  assign busPop    = writeSel && bus_req_ready;
  assign storePush = mem_writeM && (!fifoFull || busPop);
  assign lastPop   = busPop && (fifoCount == (PW+1)'(1)) && !storePush;

  wbuf_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (WBUF_DEPTH)
  ) uWbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (storePush),
    .pushAddr  (alu_resultM),
    .pushData  (write_dataM),
    .pop       (busPop),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .count     (fifoCount),
    .headAddr  (headAddr),
    .headData  (headData)
`ifdef DMEM_BRIDGE_FWD_EN
    ,
    .viewAddr  (viewAddr),
    .viewData  (viewData),
    .viewValid (viewValid)
`endif
  );

`ifdef DMEM_BRIDGE_FWD_EN
  for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : gFwdCmp
    assign fwdMatch[gi] = viewValid[gi] && (viewAddr[gi] == alu_resultM);
  end

  // Later slots are younger, so the last hit in the scan wins.
  always_comb begin
    fwdData = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (fwdMatch[i]) fwdData = viewData[i];
    end
  end

  assign fwdHit = |fwdMatch;
`endif

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (readReq) begin
          if (fifoEmpty) stateNext = RD_REQ;
          else           stateNext = DRAIN;
`ifdef DMEM_BRIDGE_FWD_EN
          if (fwdHit)    stateNext = RD_DONE;
`endif
        end
      end
      DRAIN:   if (fifoEmpty || lastPop) stateNext = RD_REQ;
      RD_REQ:  if (bus_req_ready)        stateNext = RD_WAIT;
      RD_WAIT: if (bus_rsp_valid)        stateNext = RD_DONE;
      RD_DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      rdAddrReg   <= '0;
      readDataReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (startRead) rdAddrReg <= alu_resultM;
      if ((stateReg == RD_WAIT) && bus_rsp_valid) readDataReg <= bus_rsp_rdata;
`ifdef DMEM_BRIDGE_FWD_EN
      if (startRead && fwdHit) readDataReg <= fwdData;
`endif
    end
  end

  // Stores keep the channel outside the read phases; the read address is latched
  // so the request stays stable while ready is low.
  assign bus_req_valid = writeSel || (stateReg == RD_REQ);
  assign bus_req_we    = writeSel;
  assign bus_req_addr  = writeSel ? headAddr : rdAddrReg;
  assign bus_req_wdata = writeSel ? headData : '0;

  assign read_dataM  = readDataReg;
  assign read_validM = (stateReg == RD_DONE);

  // Gated by rst_n so the pipeline sees no stall while reset is held.
  assign stall_memM = rst_n &&
                      ((mem_writeM && fifoFull && !busPop) ||
                       (readReq && (stateReg != RD_DONE)));

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; bus handshakes are logged one per line.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_resultM;
  logic [31:0] write_dataM;
  logic        mem_writeM;
  logic        mem_readM;
  logic        stall_memM;
  logic [31:0] read_dataM;
  logic        read_validM;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  int checkCount = 0;
  int failCount  = 0;

  logic        logWe   [$];
  logic [31:0] logAddr [$];
  logic [31:0] logData [$];

  always #5 clk = ~clk;

  dmem_bridge #(
    .AW         (32),
    .DW         (32),
    .WBUF_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_resultM   (alu_resultM),
    .write_dataM   (write_dataM),
    .mem_writeM    (mem_writeM),
    .mem_readM     (mem_readM),
    .stall_memM    (stall_memM),
    .read_dataM    (read_dataM),
    .read_validM   (read_validM),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  // Inputs only change just after posedge, so a negedge sample sees the handshake.
  always @(negedge clk) begin
    if (rst_n && bus_req_valid && bus_req_ready) begin
      logWe.push_back(bus_req_we);
      logAddr.push_back(bus_req_addr);
      logData.push_back(bus_req_wdata);
      $display("[%0t] bus %s addr=0x%08h data=0x%08h", $time,
               bus_req_we ? "WR" : "RD", bus_req_addr, bus_req_wdata);
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    logWe.delete();
    logAddr.delete();
    logData.delete();
  endtask

  // Runs an already-presented load to completion, answering one cycle after a read handshake.
  task automatic runLoad(input logic [31:0] rspData, output int stalls, output logic done);
    logic rspDue;
    rspDue = 1'b0;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (read_validM) begin
        done = 1'b1;
        break;
      end
      if (stall_memM) stalls++;
      rspDue = bus_req_valid && bus_req_ready && !bus_req_we;
      tick();
      bus_rsp_valid = rspDue;
      bus_rsp_rdata = rspData;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   stalls;
    logic done;

    rst_n         = 1'b0;
    alu_resultM   = '0;
    write_dataM   = '0;
    mem_writeM    = 1'b0;
    mem_readM     = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    #12;
    checkVal("rst_stall", stall_memM, 0);
    checkVal("rst_valid", bus_req_valid, 0);
    checkVal("rst_rvalid", read_validM, 0);
    checkVal("rst_rdata", read_dataM, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill the buffer with ready low, then overflow by one store.
    clearLog();
    for (int i = 0; i < 4; i++) begin
      mem_writeM  = 1'b1;
      alu_resultM = 32'h100 + 32'(4 * i);
      write_dataM = 32'hA0 + 32'(i);
      #1;
      checkVal($sformatf("fill_stall%0d", i), stall_memM, 0);
      tick();
    end
    alu_resultM = 32'h110;
    write_dataM = 32'hA4;
    #1;
    checkVal("full_stall", stall_memM, 1);
    checkVal("full_head_addr", bus_req_addr, 32'h100);
    tick();
    #1;
    checkVal("full_stall_hold", stall_memM, 1);
    checkVal("full_head_stable", bus_req_addr, 32'h100);
    tick();
    bus_req_ready = 1'b1;
    #1;
    checkVal("full_pop_accept", stall_memM, 0);
    tick();
    mem_writeM = 1'b0;
    repeat (6) tick();
    checkVal("drain_cnt", logAddr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkVal($sformatf("drain_addr%0d", i), logAddr[i], 32'h100 + 32'(4 * i));
      checkVal($sformatf("drain_data%0d", i), logData[i], 32'hA0 + 32'(i));
    end
    checkVal("drain_idle", bus_req_valid, 0);

    // Minimum-latency load with an empty buffer.
    clearLog();
    mem_readM   = 1'b1;
    alu_resultM = 32'h200;
    #1;
    checkVal("ld_c1_stall", stall_memM, 1);
    checkVal("ld_c1_novalid", bus_req_valid, 0);
    tick();
    #1;
    checkVal("ld_c2_stall", stall_memM, 1);
    checkVal("ld_c2_valid", bus_req_valid, 1);
    checkVal("ld_c2_we", bus_req_we, 0);
    checkVal("ld_c2_addr", bus_req_addr, 32'h200);
    tick();
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hDEADBEEF;
    #1;
    checkVal("ld_c3_stall", stall_memM, 1);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    checkVal("ld_c4_stall", stall_memM, 0);
    checkVal("ld_c4_rvalid", read_validM, 1);
    checkVal("ld_c4_rdata", read_dataM, 32'hDEADBEEF);
    tick();
    mem_readM = 1'b0;

    // A response while idle must not touch read data.
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h55;
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    checkVal("stray_rsp_rdata", read_dataM, 32'hDEADBEEF);
    checkVal("stray_rsp_rvalid", read_validM, 0);

    // Store then load to the same address.
    clearLog();
    tick();
    bus_req_ready = 1'b0;
    mem_writeM    = 1'b1;
    alu_resultM   = 32'h300;
    write_dataM   = 32'h11;
    tick();
    mem_writeM    = 1'b0;
    mem_readM     = 1'b1;
    bus_req_ready = 1'b1;
    runLoad(32'h77, stalls, done);
    checkVal("raw_done", done, 1);
    checkVal("raw_wr_first", logWe[0], 1);
    checkVal("raw_wr_addr", logAddr[0], 32'h300);
    checkVal("raw_wr_data", logData[0], 32'h11);
`ifdef DMEM_BRIDGE_FWD_EN
    checkVal("raw_fwd_stalls", stalls, 1);
    checkVal("raw_fwd_rdata", read_dataM, 32'h11);
    tick();
    mem_readM = 1'b0;
    repeat (3) tick();
    checkVal("raw_fwd_nobusrd", logAddr.size(), 1);
`else
    checkVal("raw_rd_cnt", logAddr.size(), 2);
    checkVal("raw_rd_second", logWe[1], 0);
    checkVal("raw_rd_addr", logAddr[1], 32'h300);
    checkVal("raw_rdata", read_dataM, 32'h77);
    tick();
    mem_readM = 1'b0;
    tick();
`endif

    // Read request held against ready low, then reset during RD_WAIT.
    bus_req_ready = 1'b0;
    mem_readM     = 1'b1;
    alu_resultM   = 32'h400;
    tick();
    alu_resultM = 32'h999;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkVal($sformatf("hold_valid%0d", i), bus_req_valid, 1);
      checkVal($sformatf("hold_addr%0d", i), bus_req_addr, 32'h400);
      checkVal($sformatf("hold_we%0d", i), bus_req_we, 0);
      tick();
    end
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    checkVal("wait_stall", stall_memM, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst_stall", stall_memM, 0);
    checkVal("arst_valid", bus_req_valid, 0);
    checkVal("arst_rvalid", read_validM, 0);
    checkVal("arst_rdata", read_dataM, 0);
    tick();
    tick();
    rst_n         = 1'b1;
    mem_readM     = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hBAD;
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    checkVal("late_rsp_rvalid", read_validM, 0);
    checkVal("late_rsp_rdata", read_dataM, 0);
    checkVal("late_rsp_valid", bus_req_valid, 0);

    // Reset discards buffered stores.
    tick();
    mem_writeM  = 1'b1;
    alu_resultM = 32'h600;
    write_dataM = 32'h66;
    tick();
    mem_writeM = 1'b0;
    #1;
    checkVal("pre_rst_valid", bus_req_valid, 1);
    rst_n = 1'b0;
    #1;
    checkVal("rst_discard_valid", bus_req_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checkVal("post_rst_empty", bus_req_valid, 0);

    // Simultaneous read and write: the store wins.
    clearLog();
    mem_readM   = 1'b1;
    mem_writeM  = 1'b1;
    alu_resultM = 32'h500;
    write_dataM = 32'h5A;
    #1;
    checkVal("both_stall", stall_memM, 0);
    tick();
    mem_readM  = 1'b0;
    mem_writeM = 1'b0;
    #1;
    checkVal("both_valid", bus_req_valid, 1);
    checkVal("both_we", bus_req_we, 1);
    checkVal("both_addr", bus_req_addr, 32'h500);
    checkVal("both_wdata", bus_req_wdata, 32'h5A);
    tick();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    tick();
    #1;
    checkVal("both_cnt", logAddr.size(), 1);
    checkVal("both_log_we", logWe[0], 1);
    checkVal("both_idle", bus_req_valid, 0);
    checkVal("both_rvalid", read_validM, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, power of two, at least 2: write-buffer entries.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  in  1: rising-edge clock.
REQ-006 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-007 SHALL have port alu_resultM  in  AW: memory-stage address.
REQ-008 SHALL have port write_dataM  in  DW: store data.
REQ-009 SHALL have port mem_writeM  in  1: store request.
REQ-010 SHALL have port mem_readM  in  1: load request.
REQ-011 SHALL have port stall_memM  out  1: pipeline stall to the hazard logic.
REQ-012 SHALL have port read_dataM  out  DW: load result.
REQ-013 SHALL have port read_validM  out  1: read_dataM is valid.
REQ-014 SHALL have ports bus_req_valid out 1, bus_req_ready in 1, bus_req_we out 1, bus_req_addr out AW, bus_req_wdata out DW: request channel.
REQ-015 SHALL have ports bus_rsp_valid in 1, bus_rsp_rdata in DW: read-response channel.

Function
REQ-016 SHALL hold stores in a WBUF_DEPTH-entry FIFO of {addr,data}, drained in order.
REQ-017 SHALL push a store when mem_writeM=1 and the FIFO is not full, or is full and pops in the same cycle; stall_memM=0 in that cycle.
REQ-018 SHALL drive stall_memM=1 combinationally when mem_writeM=1 and the FIFO is full with no same-cycle pop.
REQ-019 SHALL present the FIFO head with bus_req_we=1 whenever the FIFO is non-empty and the FSM is IDLE or DRAIN; pop on valid&&ready.
REQ-020 SHALL hold bus_req_valid, bus_req_addr, bus_req_wdata and bus_req_we stable while valid=1 and ready=0.
REQ-021 SHALL implement FSM states IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE.
REQ-022 From IDLE with mem_readM=1, the FSM SHALL go to DRAIN if the FIFO is non-empty, else to RD_REQ.
REQ-023 From DRAIN, the FSM SHALL go to RD_REQ when the last entry pops.
REQ-024 In RD_REQ, SHALL drive bus_req_valid=1 and we=0 with the latched address; on ready, go to RD_WAIT.
REQ-025 In RD_WAIT, on bus_rsp_valid, SHALL register bus_rsp_rdata into read_dataM and go to RD_DONE.
REQ-026 In RD_DONE, SHALL drive read_validM=1 and stall_memM=0, then return to IDLE.
REQ-027 SHALL drive stall_memM=1 whenever mem_readM=1 and the state is not RD_DONE.
REQ-028 When mem_readM and mem_writeM are both 1, SHALL give the write priority and ignore the read.
REQ-029 Minimum load latency with an empty FIFO, immediate ready and next-cycle response SHALL be 3 stall cycles, with read_validM in the 4th cycle.
REQ-030 SHALL ignore bus_rsp_valid outside RD_WAIT.
REQ-031 SHALL issue no store to the bus while in RD_REQ or RD_WAIT.

Reset
REQ-032 On rst_n=0, SHALL asynchronously set the state to IDLE, FIFO pointers and count to 0 (entries discarded), read_dataM=0, read_validM=0, bus_req_valid=0 and stall_memM=0, including mid-transaction.

Configuration
REQ-033 SHALL use macro DMEM_BRIDGE_FWD_EN to control store-to-load forwarding.
REQ-034 With DMEM_BRIDGE_FWD_EN defined: a load in IDLE whose address matches any FIFO entry (full AW compare) SHALL go directly to RD_DONE with the youngest matching data (1 stall cycle) and issue no bus read.
REQ-035 Without DMEM_BRIDGE_FWD_EN: loads SHALL always follow REQ-022 and there SHALL be no compare logic.

Structure
REQ-036 SHALL place the state enum and parameter defaults in package dmem_bridge_pkg.
REQ-037 SHALL implement the FIFO as sub-module wbuf_fifo (push, pop, full, empty, head, entry-array view for forwarding).

Verification
REQ-038 Bench SHALL cover: 4 stores to 0x100..0x10C with ready=0 followed by a 5th store -> stall_memM=1 on the 5th; ready=1 -> in-order drain, 5th accepted on first pop.
REQ-039 Bench SHALL cover: empty FIFO, load 0x200, ready=1, rsp 0xDEADBEEF next cycle -> 3 stall cycles, then read_validM=1 with read_dataM=0xDEADBEEF.
REQ-040 Bench SHALL cover: store 0x300=0x11 then load 0x300, FWD off -> bus write precedes bus read; FWD on -> read_dataM=0x11 after 1 stall cycle, no bus read.
REQ-041 Bench SHALL cover: rst_n low during RD_WAIT -> all outputs 0 immediately; a late bus_rsp_valid is ignored.
REQ-042 Bench SHALL cover: bus_req_ready held 0 for 5 cycles in RD_REQ -> addr and valid stable throughout.
REQ-043 Bench SHALL cover: mem_readM=mem_writeM=1 -> store pushed, no read started.
